// File: rtl/polyphase_decim_fir.sv
// Decimating FIR with one time-multiplexed MAC, circular sample history and
// a runtime-writable coefficient bank. One output per DECIM accepted samples.
// Optional feature macro: FIR_ROUND_SAT_EN (round half up + saturate, adds sat_flag).
module polyphase_decim_fir #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 32,
    parameter int DECIM  = 2,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     coef_err
`ifdef FIR_ROUND_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int AW     = $clog2(TAPS);
    localparam int CW     = $clog2(TAPS + 1);
    localparam int PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    localparam logic [AW-1:0] LAST_IDX   = AW'(TAPS - 1);
    localparam logic [CW-1:0] MAC_LAST   = CW'(TAPS);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   TAPS_EXT   = (AW + 1)'(TAPS);

    typedef enum logic [1:0] {COLLECT, MAC, OUT} state_t;

    state_t                    state, state_nxt;
    logic signed [DATA_W-1:0]  hist [TAPS];
    logic signed [COEF_W-1:0]  coef [TAPS];
    logic [AW-1:0]             wr_ptr, rd_idx, tap_idx;
    logic [PW-1:0]             phase;
    logic [CW-1:0]             mac_cnt;
    logic signed [PROD_W-1:0]  prod_r;
    logic signed [ACC_W-1:0]   acc, acc_next;
    logic                      started, accept, last_tap, addr_ok;
    logic [OUT_W-1:0]          narrow;

    assign accept   = in_valid && in_ready;
    assign last_tap = (mac_cnt == MAC_LAST);
    assign addr_ok  = ({1'b0, coef_addr} < TAPS_EXT);
    assign acc_next = acc + $signed({{AW{prod_r[PROD_W-1]}}, prod_r});

    // Coefficient index for the multiply stage; parked at 0 on the drain cycle.
    always_comb begin
        tap_idx = last_tap ? '0 : mac_cnt[AW-1:0];
    end

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ((ACC_W + 1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-(64'sd1 <<< (OUT_W - 1)));

    logic signed [ACC_W:0] rounded;
    logic                  sat_hit;

    // Round half up, shift, then clamp into the output range.
    always_comb begin
        rounded = ($signed({acc_next[ACC_W-1], acc_next}) + RND) >>> SHIFT;
        sat_hit = 1'b0;
        narrow  = OUT_W'(rounded);
        if (rounded > SAT_MAX) begin
            narrow  = OUT_W'(SAT_MAX);
            sat_hit = 1'b1;
        end else if (rounded < SAT_MIN) begin
            narrow  = OUT_W'(SAT_MIN);
            sat_hit = 1'b1;
        end
    end
`else
    // Arithmetic shift then keep the low OUT_W bits (floor, wrap on overflow).
    always_comb begin
        narrow = OUT_W'(acc_next >>> SHIFT);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = started;
                if (in_valid && started && (phase == PHASE_LAST)) state_nxt = MAC;
            end
            MAC: begin
                if (last_tap) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Sample history, phase tracking and the pipelined MAC. The product is
    // registered, so MAC spans TAPS+1 cycles: multiply on counts 0..TAPS-1,
    // accumulate on counts 1..TAPS, capturing the narrowed result on the last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started  <= 1'b0;
            wr_ptr   <= '0;
            rd_idx   <= '0;
            phase    <= '0;
            mac_cnt  <= '0;
            prod_r   <= '0;
            acc      <= '0;
            out_data <= '0;
`ifdef FIR_ROUND_SAT_EN
            sat_flag <= 1'b0;
`endif
            for (int unsigned i = 0; i < TAPS; i++) hist[i] <= '0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                hist[wr_ptr] <= in_data;
                wr_ptr       <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                rd_idx       <= wr_ptr;
                phase        <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
                mac_cnt      <= '0;
            end
            if (state == MAC) begin
                mac_cnt <= mac_cnt + 1'b1;
                prod_r  <= hist[rd_idx] * coef[tap_idx];
                rd_idx  <= (rd_idx == '0) ? LAST_IDX : rd_idx - 1'b1;
                acc     <= (mac_cnt == '0) ? '0 : acc_next;
                if (last_tap) begin
                    out_data <= narrow;
`ifdef FIR_ROUND_SAT_EN
                    sat_flag <= sat_hit;
`endif
                end
            end
`ifdef FIR_ROUND_SAT_EN
            if (state == OUT && out_ready) sat_flag <= 1'b0;
`endif
        end
    end

    // Coefficient bank: writes only land in COLLECT with an in-range index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef_err <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) coef[i] <= '0;
        end else begin
            coef_err <= 1'b0;
            if (coef_we) begin
                if (state == COLLECT && addr_ok) coef[coef_addr] <= coef_wdata;
                else                             coef_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_polyphase_decim_fir.sv
// Directed bench for polyphase_decim_fir: an 8-tap decimate-by-2 instance for
// impulse/step/backpressure/reset cases and a 5-tap, 8-bit-output instance for
// narrowing and coefficient-address range cases.
module tb_polyphase_decim_fir;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance: TAPS=8, DECIM=2, SHIFT=0, OUT_W=16.
    logic        in_valid, in_ready, out_valid, out_ready, coef_we, coef_err;
    logic [15:0] in_data, out_data, coef_wdata;
    logic [2:0]  coef_addr;

    // Narrow instance: TAPS=5, DECIM=1, SHIFT=0, OUT_W=8.
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_coef_we, n_coef_err;
    logic [15:0] n_in_data, n_coef_wdata;
    logic [7:0]  n_out_data;
    logic [2:0]  n_coef_addr;
`ifdef FIR_ROUND_SAT_EN
    logic        sat_main, n_sat;
`endif

    int vectors    = 0;
    int miscompares = 0;

    polyphase_decim_fir #(
        .DATA_W(16), .COEF_W(16), .TAPS(8), .DECIM(2), .OUT_W(16), .SHIFT(0)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_err(coef_err)
`ifdef FIR_ROUND_SAT_EN
        , .sat_flag(sat_main)
`endif
    );

    polyphase_decim_fir #(
        .DATA_W(16), .COEF_W(16), .TAPS(5), .DECIM(1), .OUT_W(8), .SHIFT(0)
    ) u_nar (
        .clk(clk), .reset(reset),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .coef_we(n_coef_we), .coef_addr(n_coef_addr), .coef_wdata(n_coef_wdata),
        .coef_err(n_coef_err)
`ifdef FIR_ROUND_SAT_EN
        , .sat_flag(n_sat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for out_valid counting edges since the accept edge; consumes the
    // output when out_ready is high.
    task automatic expect_out(input string tag, input logic [15:0] exp, input int lat);
        int n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (lat >= 0) check({tag, "_lat"}, 32'(n), 32'(lat));
        check(tag, 32'(out_data), 32'(exp));
        if (out_ready) begin
            tick();
            check({tag, "_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 8; k++) begin
            coef_we    = 1'b1;
            coef_addr  = 3'(k);
            coef_wdata = 16'(k + 1);
            tick();
            check($sformatf("ramp_err%0d", k), 32'(coef_err), 32'd0);
        end
        coef_we = 1'b0;
    endtask

    task automatic imp_run(input string pfx);
        logic [15:0] e [5] = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd0};
        for (int i = 0; i < 5; i++) begin
            push((i == 0) ? 16'd1 : 16'd0);
            push(16'd0);
            expect_out($sformatf("%s%0d", pfx, i), e[i], 9);
        end
    endtask

    task automatic n_wait_out(output int n);
        n = 0;
        while (!n_out_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [15:0] ce [8] = '{16'd3, 16'd10, 16'd21, 16'd36, 16'd36, 16'd36, 16'd36, 16'd36};
        logic [15:0] ze [4] = '{16'd33, 16'd26, 16'd15, 16'd0};
        logic        stable, seen;
        int          n;

        reset = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b1;
        n_coef_we = 1'b0; n_coef_addr = '0; n_coef_wdata = '0;
        #1 reset = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_coef_err", 32'(coef_err), 32'd0);
        reset = 1'b0;
        check("rst_rel_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("rst_rel_ready_high", 32'(in_ready), 32'd1);

        // Narrow instance: sample accept and coefficient write in one cycle.
        n_coef_we = 1'b1; n_coef_addr = 3'd0; n_coef_wdata = 16'd127;
        n_in_valid = 1'b1; n_in_data = 16'd127;
        check("nar_ready", 32'(n_in_ready), 32'd1);
        tick();
        n_coef_we = 1'b0; n_in_valid = 1'b0;
        check("nar_same_cycle_err", 32'(n_coef_err), 32'd0);
        n_wait_out(n);
        check("nar_lat", 32'(n), 32'd6);
`ifdef FIR_ROUND_SAT_EN
        check("nar_pos", 32'(n_out_data), 32'h7F);
        check("nar_pos_sat", 32'(n_sat), 32'd1);
`else
        check("nar_pos", 32'(n_out_data), 32'h01);
`endif
        tick();
        check("nar_drop", 32'(n_out_valid), 32'd0);

        // Out-of-range coefficient address (5 taps, address 6).
        n_coef_we = 1'b1; n_coef_addr = 3'd6; n_coef_wdata = 16'd5;
        tick();
        n_coef_we = 1'b0;
        check("nar_oor_err", 32'(n_coef_err), 32'd1);
        tick();
        check("nar_oor_clear", 32'(n_coef_err), 32'd0);

        // h[4]=2, then x=-3: y = 127*(-3) = -381.
        n_coef_we = 1'b1; n_coef_addr = 3'd4; n_coef_wdata = 16'd2;
        tick();
        n_coef_we = 1'b0;
        n_in_valid = 1'b1; n_in_data = 16'hFFFD;
        tick();
        n_in_valid = 1'b0;
        n_wait_out(n);
`ifdef FIR_ROUND_SAT_EN
        check("nar_neg", 32'(n_out_data), 32'h80);
        check("nar_neg_sat", 32'(n_sat), 32'd1);
`else
        check("nar_neg", 32'(n_out_data), 32'h83);
`endif
        tick();

        // Main instance: h[k]=k+1, impulse then constant input.
        load_ramp();
        imp_run("imp");
        for (int i = 0; i < 8; i++) begin
            push(16'd1);
            push(16'd1);
            expect_out($sformatf("const%0d", i), ce[i], 9);
        end

        // Backpressure: hold out_ready low for 20 cycles in OUT.
        out_ready = 1'b0;
        push(16'd1);
        push(16'd1);
        expect_out("bp", 16'd36, 9);
        in_valid = 1'b1; in_data = 16'd1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 16'd36 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_hold", 32'(stable), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        check("bp_hs_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        push(16'd1);
        expect_out("bp_next", 16'd36, 9);

        // Coefficient write during MAC is dropped.
        push(16'd1);
        push(16'd1);
        coef_we = 1'b1; coef_addr = 3'd3; coef_wdata = 16'd100;
        tick();
        coef_we = 1'b0;
        check("cmac_err", 32'(coef_err), 32'd1);
        tick();
        check("cmac_err_clear", 32'(coef_err), 32'd0);
        expect_out("cmac", 16'd36, 7);
        for (int i = 0; i < 4; i++) begin
            push(16'd0);
            push(16'd0);
            expect_out($sformatf("flush%0d", i), ze[i], 9);
        end
        imp_run("cimp");

        // Reset in MAC cycle 4 discards the pending output.
        push(16'd1);
        push(16'd0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        check("rmac_valid", 32'(out_valid), 32'd0);
        check("rmac_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("rmac_no_valid", 32'(seen), 32'd0);
        check("rmac_ready_back", 32'(in_ready), 32'd1);
        load_ramp();
        imp_run("rimp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/polyphase_decim_fir.md
Name: polyphase_decim_fir

Overview:
- Parametrised decimating FIR: accepts a stream of signed samples and emits one filtered output per DECIM accepted inputs.
- Uses one time-multiplexed multiply-accumulate unit, a circular sample history and a runtime-writable coefficient bank.
- Generalises the fixed halfband decimator to arbitrary tap count, decimation factor and data/coefficient widths.
- Sits between the ADC front-end sample stream and downstream channel processing.

Parameters:
- DATA_W, 16, input sample width (signed two's complement)
- COEF_W, 16, coefficient width (signed)
- TAPS, 32, filter length (2..256)
- DECIM, 2, decimation factor (1..TAPS)
- OUT_W, 16, output sample width (signed)
- SHIFT, 15, arithmetic right shift applied to the accumulator before output narrowing

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_W  decimated filtered sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index k
- coef_wdata  in  COEF_W  coefficient value h[k]
- coef_err  out  1  one-cycle pulse: coefficient write dropped

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - On reset: in_ready=0, out_valid=0, out_data=0, coef_err=0.
  - Sample history cleared to 0; write pointer=0; phase counter=0; accumulator=0; state=COLLECT.
  - Coefficients cleared to 0.
  - in_ready rises on the first clk edge after reset deasserts.
- Arithmetic:
  - Accumulator width ACC_W = DATA_W + COEF_W + clog2(TAPS); products are signed × signed and sign-extended.
  - Output equation: y[m] = sum over k=0..TAPS-1 of h[k]·x[n−k], where n is the index of the DECIM-th sample accepted in the current phase.
- FSM state COLLECT:
  - in_ready=1. A sample is accepted on in_valid && in_ready; it is written at the write pointer and the pointer wraps modulo TAPS.
  - The phase counter increments; when it reaches DECIM−1 on an accept, it wraps to 0 and the FSM moves to MAC.
- FSM state MAC:
  - in_ready=0. The accumulator is cleared, then one tap is accumulated per cycle for TAPS cycles, newest sample first.
  - The history index walks backwards from the newest sample with wrap-around.
  - After the last tap, the FSM moves to OUT.
- FSM state OUT:
  - out_data = narrowed (acc >>> SHIFT); out_valid=1.
  - out_valid and out_data stay stable until out_ready is seen high.
  - On out_valid && out_ready: out_valid=0, next state COLLECT.
- Latency: out_valid asserts TAPS+1 cycles after the accepting edge of the DECIM-th sample.
  - Throughput ceiling: one input per cycle in COLLECT only.
  - in_ready=0 during MAC and OUT, so backpressure propagates upstream.
- Coefficient writes:
  - In COLLECT, a write takes effect at that clk edge.
  - Writes in MAC or OUT are dropped and coef_err pulses for 1 cycle.
  - Out-of-range coef_addr (≥TAPS) is dropped with a coef_err pulse.
- Boundary cases:
  - DECIM=1: every accepted sample triggers MAC.
  - Input accept and coefficient write in the same COLLECT cycle: both take effect.
  - out_ready held high: OUT lasts exactly 1 cycle.
  - Reset mid-MAC or mid-OUT: returns immediately to reset state, and the pending output is discarded.
  - First outputs after reset use zero history for samples not yet received.
- Narrowing without the optional feature: keep the low OUT_W bits of (acc >>> SHIFT); wrap on overflow, truncate toward −∞.

Optional Feature:
- Macro FIR_ROUND_SAT_EN.
- Defined:
  - Add 2^(SHIFT−1) before the shift (round half up; skipped when SHIFT=0).
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Add output port sat_flag (1 bit), asserted with out_valid when saturation occurred, and reset to 0.
- Undefined: truncate/wrap as above; no sat_flag port.

Test Plan:
- Config TAPS=8, DECIM=2, SHIFT=0, OUT_W=16, h[k]=k+1, out_ready=1. Input x=1,0,0,0,0,0,0,0,0,0 → outputs 2,4,6,8,0; each out_valid exactly TAPS+1=9 cycles after the 2nd, 4th, … accept.
- Same config, constant input x=1 for 16 samples → outputs 3,10,21,36,36,36,36,36.
- Hold out_ready=0 for 20 cycles during OUT → out_data stable, in_ready=0 throughout; first accept occurs the cycle after the out_ready handshake.
- Write coef during MAC (addr 3, value 100) → coef_err one-cycle pulse; h[3] unchanged, verified by the next impulse response.
- Assert reset in MAC cycle 4 → out_valid never asserts; after release, an impulse test reproduces the first scenario exactly from the zero history.
- With FIR_ROUND_SAT_EN: OUT_W=8, SHIFT=0, h[0]=127, others 0, x=127 → out_data=127, sat_flag=1. Without the macro → out_data=0x01 (wrapped low 8 bits of 16129).
